// File: rtl/wr_rd_stim_gen.sv
// Reset/write/read stimulus generator: a rising trigger arms a countdown,
// then drops rst_o, fires one wr and one rd pulse, and re-asserts rst_o.
module wr_rd_stim_gen #(
   parameter int ARM_CYC = 2,
   parameter int WR_DLY  = 2,
   parameter int RD_DLY  = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             temp,
   output logic             rst_o,
   output logic             wr,
   output logic             rd,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] run_cnt
);

   localparam int M    = (WR_DLY > RD_DLY) ? WR_DLY : RD_DLY;
   localparam int LAST = ARM_CYC + M;
   localparam int KW   = $clog2(LAST + 2) + 1;

   // Edge indices (relative to the trigger edge) at which each output is set
   localparam logic [KW-1:0] K_LO   = KW'(ARM_CYC - 1);
   localparam logic [KW-1:0] K_WR   = KW'(ARM_CYC + WR_DLY - 1);
   localparam logic [KW-1:0] K_RD   = KW'(ARM_CYC + RD_DLY - 1);
   localparam logic [KW-1:0] K_LAST = KW'(LAST);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [KW-1:0]    kk;
   logic             temp_q;
   logic             rise;
   logic             act;
   logic             rst_o_q, rst_o_d;
   logic             wr_q, wr_d;
   logic             rd_q, rd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign rise = temp & ~temp_q;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      rst_o_d = 1'b1;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      act     = 1'b0;
      kk      = k_q;
      unique case (state_q)
         S_IDLE: begin
            act = rise;
            kk  = '0;
         end
         S_ARM, S_RUN: act = 1'b1;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (act) begin
         busy_d  = (kk != K_LAST);
         rst_o_d = (kk < K_LO) || (kk == K_LAST);
         wr_d    = (kk == K_WR);
         rd_d    = (kk == K_RD);
         k_d     = kk + 1'b1;
         if (kk == K_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            k_d     = '0;
         end else if (kk >= K_LO) begin
            state_d = S_RUN;
         end else begin
            state_d = S_ARM;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         temp_q  <= 1'b0;
         rst_o_q <= 1'b1;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         temp_q  <= temp;
         rst_o_q <= rst_o_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rst_o   = rst_o_q;
   assign wr      = wr_q;
   assign rd      = rd_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign run_cnt = cnt_q;

endmodule

// File: tb/tb_wr_rd_stim_gen.sv
// Bench for wr_rd_stim_gen: three parameterisations checked every cycle
// against a timeline model plus fixed timing literals.
`timescale 1ns/100ps
module tb_wr_rd_stim_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic temp = 1'b0;

   logic [2:0] ro_w, wr_w, rd_w, bz_w, dn_w;
   logic [7:0] c0, c2;
   logic [1:0] c1;

   int checks = 0;
   int failures = 0;

   int arm_p[3] = '{2, 2, 1};
   int wr_p[3]  = '{2, 3, 0};
   int rd_p[3]  = '{4, 3, 1};
   int cw_p[3]  = '{8, 2, 8};

   int e0[3]  = '{-1, -1, -1};
   int cnt[3] = '{0, 0, 0};
   int n = 0;
   logic ptemp = 1'b0;

   int tw0 = -1, tr0 = -1, td0 = -1, lo_f = -1, lo_l = -1;
   int tw1 = -1, tr1 = -1, td1 = -1;
   int seq[5] = '{1, 2, 3, 0, 1};

   always #5 clk = ~clk;

   wr_rd_stim_gen #(.ARM_CYC(2), .WR_DLY(2), .RD_DLY(4), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .temp(temp), .rst_o(ro_w[0]), .wr(wr_w[0]),
      .rd(rd_w[0]), .busy(bz_w[0]), .done(dn_w[0]), .run_cnt(c0));
   wr_rd_stim_gen #(.ARM_CYC(2), .WR_DLY(3), .RD_DLY(3), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .temp(temp), .rst_o(ro_w[1]), .wr(wr_w[1]),
      .rd(rd_w[1]), .busy(bz_w[1]), .done(dn_w[1]), .run_cnt(c1));
   wr_rd_stim_gen #(.ARM_CYC(1), .WR_DLY(0), .RD_DLY(1), .CNT_W(8)) u2 (
      .clk(clk), .rst(rst), .temp(temp), .rst_o(ro_w[2]), .wr(wr_w[2]),
      .rd(rd_w[2]), .busy(bz_w[2]), .done(dn_w[2]), .run_cnt(c2));

   function automatic int lastk(input int i);
      return arm_p[i] + ((wr_p[i] > rd_p[i]) ? wr_p[i] : rd_p[i]);
   endfunction

   function automatic int getcnt(input int i);
      case (i)
         0: return int'(c0);
         1: return int'(c1);
         default: return int'(c2);
      endcase
   endfunction

   task automatic chk(input string nm, input int i, input int got, input int ex);
      checks++;
      if (got != ex) begin
         failures++;
         $display("FAIL %s inst%0d t=%0t got=%0d exp=%0d", nm, i, $time, got, ex);
      end
   endtask

   // Timeline model: remembers the trigger edge index of each instance
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ptemp = 1'b0;
         for (int i = 0; i < 3; i++) begin
            e0[i]  = -1;
            cnt[i] = 0;
         end
      end else begin
         n++;
         for (int i = 0; i < 3; i++) begin
            if (e0[i] >= 0 && n - e0[i] == lastk(i))
               cnt[i] = (cnt[i] + 1) % (1 << cw_p[i]);
            if (temp && !ptemp && (e0[i] < 0 || n - e0[i] >= lastk(i) + 2))
               e0[i] = n;
         end
         ptemp = temp;
      end
   end

   always @(negedge clk) begin
      int t;
      t = int'($time) + 5;
      for (int i = 0; i < 3; i++) begin
         int s, lk;
         bit run;
         run = (e0[i] >= 0);
         s   = n - e0[i] + 1;
         lk  = lastk(i);
         chk("busy", i, int'(bz_w[i]), int'(run && s >= 1 && s <= lk));
         chk("rst_o", i, int'(ro_w[i]), int'(!(run && s >= arm_p[i] && s <= lk)));
         chk("wr", i, int'(wr_w[i]), int'(run && s == arm_p[i] + wr_p[i]));
         chk("rd", i, int'(rd_w[i]), int'(run && s == arm_p[i] + rd_p[i]));
         chk("done", i, int'(dn_w[i]), int'(run && s == lk + 1));
         chk("run_cnt", i, getcnt(i), cnt[i]);
      end
      if (t < 100) begin
         if (wr_w[0] && tw0 < 0) tw0 = t;
         if (rd_w[0] && tr0 < 0) tr0 = t;
         if (dn_w[0] && td0 < 0) td0 = t;
         if (!ro_w[0]) begin
            if (lo_f < 0) lo_f = t;
            lo_l = t;
         end
         if (wr_w[1] && tw1 < 0) tw1 = t;
         if (rd_w[1] && tr1 < 0) tr1 = t;
         if (dn_w[1] && td1 < 0) td1 = t;
      end
   end

   task automatic step(input logic v);
      @(posedge clk);
      #2 temp = v;
   endtask

   task automatic chk_reset_vals();
      for (int i = 0; i < 3; i++) begin
         chk("rst_rst_o", i, int'(ro_w[i]), 1);
         chk("rst_busy", i, int'(bz_w[i]), 0);
         chk("rst_wr", i, int'(wr_w[i] | rd_w[i]), 0);
         chk("rst_done", i, int'(dn_w[i]), 0);
         chk("rst_cnt", i, getcnt(i), 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      #0.5 chk_reset_vals();
      #0.5 rst = 1'b0;
      #1 temp = 1'b1;
      #10 temp = 1'b0;
      #90;
      chk("t1_wr_time", 0, tw0, 45);
      chk("t1_rd_time", 0, tr0, 65);
      chk("t1_done_time", 0, td0, 75);
      chk("t1_lo_first", 0, lo_f, 25);
      chk("t1_lo_last", 0, lo_l, 65);
      chk("t1_cnt", 0, int'(c0), 1);
      chk("t2_wr_time", 1, tw1, 55);
      chk("t2_rd_time", 1, tr1, 55);
      chk("t2_done_time", 1, td1, 65);

      // trigger held high for 30 cycles
      step(1'b1);
      repeat (30) step(1'b1);
      repeat (12) step(1'b0);
      chk("t3_cnt", 0, int'(c0), 2);

      // retrigger mid-run, then at the first idle edge after done
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b1);
      repeat (4) step(1'b0);
      step(1'b1);
      repeat (12) step(1'b0);
      chk("t4_cnt", 0, int'(c0), 4);

      // asynchronous reset in the middle of a run
      step(1'b1);
      repeat (4) step(1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_reset_vals();
      repeat (2) @(posedge clk);
      #4 rst = 1'b0;
      repeat (3) step(1'b0);

      for (int r = 0; r < 5; r++) begin
         step(1'b1);
         repeat (15) step(1'b0);
         chk("t6_cnt_seq", 1, int'(c1), seq[r]);
      end
      chk("t5_cnt_after_rst", 0, int'(c0), 5);

      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 59) == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end
      repeat (12) step(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wr_rd_stim_gen.md
Name: wr_rd_stim_gen

Overview:
Stimulus generator that drives the reset/write/read sequence a trigger-window property checks for. A rising edge on the trigger input `temp` starts an armed countdown. The block then releases the downstream reset `rst_o` and issues exactly one `wr` pulse and one `rd` pulse while holding `rst_o` low. Once both pulses have been issued, it re-asserts `rst_o` and reports completion. It sits in the SVA lab environment as the driving end, replacing hand-written initial-block stimulus.

Parameters:
- ARM_CYC, 2: cycles from the sampled trigger rise to the first cycle `rst_o` is sampled low; legal range ≥1.
- WR_DLY, 2: cycles after `rst_o` first samples low until `wr` is sampled high; legal range ≥0.
- RD_DLY, 4: cycles after `rst_o` first samples low until `rd` is sampled high; legal range ≥0.
- CNT_W, 8: width of the completed-run counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous active-high reset.
- temp  in  1  trigger; a 0→1 change between consecutive rising edges starts a run.
- rst_o  out  1  downstream active-high reset; low only inside the run window.
- wr  out  1  single-cycle write pulse.
- rd  out  1  single-cycle read pulse.
- busy  out  1  run in progress.
- done  out  1  single-cycle run-complete pulse.
- run_cnt  out  CNT_W  count of completed runs; wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is asynchronous and active-high.
- All outputs are registered, with no combinational input→output path.
- Reset values: `rst_o`=1, `wr`=0, `rd`=0, `busy`=0, `done`=0, `run_cnt`=0, FSM=IDLE, `temp_q`=0.
- Trigger detection:
  - `temp_q` is `temp` registered every cycle.
  - A rise is `temp & ~temp_q`, sampled at rising edge E0.
  - `temp_q` resets to 0, so `temp` already high at the first edge after reset counts as a rise.
  - Holding `temp` high produces no further rises.
- Let M = max(WR_DLY, RD_DLY).
- FSM states:
  - IDLE: `rst_o`=1, `busy`=0. A rise at E0 moves to ARM.
  - ARM: counts ARM_CYC cycles. `rst_o` stays high so that it is sampled low first at E0+ARM_CYC. Then moves to RUN.
  - RUN: `rst_o` is sampled low at every edge from E0+ARM_CYC through E0+ARM_CYC+M inclusive.
    - `wr` is sampled high at exactly edge E0+ARM_CYC+WR_DLY and nowhere else.
    - `rd` is sampled high at exactly edge E0+ARM_CYC+RD_DLY and nowhere else.
    - After edge E0+ARM_CYC+M, moves to DONE.
  - DONE: one cycle. At edge E0+ARM_CYC+M+1, `done`=1, `rst_o`=1, and `run_cnt` has incremented. Then returns to IDLE.
- `busy` is sampled high at edges E0+1 through E0+ARM_CYC+M inclusive, and low in DONE and IDLE.
- WR_DLY == RD_DLY: `wr` and `rd` are high in the same single cycle. This is legal.
- WR_DLY = 0 or RD_DLY = 0: the pulse coincides with the first low-`rst_o` cycle.
- Retrigger: a rise during ARM, RUN or DONE is ignored, with no queuing. `temp_q` still tracks `temp`. A rise sampled in the first IDLE cycle after DONE starts a new run.
- `run_cnt` wraps from 2^CNT_W−1 to 0.
- Reset mid-run: `rst` asserted in any state immediately forces all outputs and the FSM to their reset values, asynchronously, with no `done` pulse. The run is abandoned and `run_cnt` is cleared to 0.
- Invariant: `wr` or `rd` high implies `rst_o`=0 and `busy`=1.

Test Plan:
1. Defaults, 10 ns clk, `temp` 0→1 at 2 ns, 1→0 at 12 ns (E0 = 5 ns edge):
   - `rst_o` sampled low at 25–65 ns.
   - `wr` sampled high only at 45 ns; `rd` sampled high only at 65 ns.
   - `done`=1 and `rst_o`=1 at 75 ns; `run_cnt`=1.
   - The checker property `$rose(temp) |-> ##2 !rst_o throughout (wr[->1] and rd[->1])` passes.
2. WR_DLY=RD_DLY=3 → `wr` and `rd` both high only at edge E0+5; `done` at E0+6; `rst_o` low at E0+2..E0+5.
3. `temp` held high for 30 cycles → exactly one run; `run_cnt`=1; no second `wr`/`rd`.
4. Second rise at E0+3 (mid-run) → ignored. A rise at the first IDLE edge after `done` → second run with identical timing; `run_cnt`=2.
5. `rst` asserted at E0+4 ns+3 ns (between edges, during RUN) → `rst_o`=1, `busy`=0, `wr`=`rd`=0 immediately; no `done`; `run_cnt`=0. After release, a new rise runs normally.
6. CNT_W=2, run 5 times → `run_cnt` sequence 1,2,3,0,1.
